// File: rtl/cnt_sched.sv
// =============================================================================
// Module      : cnt_sched
// Description : Round-robin scheduler that shares one gated up-counter between
//               NREQ requesters. Each granted cycle issues one increase pulse.
//               Controls the counter clock-gate enable (wake/hold) and stops
//               granting when the counter reaches a programmable limit.
//               Optional macro CNT_SCHED_STATS_EN adds a saturating
//               grant_total statistics output.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module cnt_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int HOLD  = 3
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active low
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic             increase,
  output logic             cg_en,
  input  logic [WIDTH-1:0] count_in,
  input  logic [WIDTH-1:0] limit,
  input  logic             clr,
  output logic             tc,
  output logic             busy
`ifdef CNT_SCHED_STATS_EN
  ,
  output logic [15:0]      grant_total
`endif
);

  localparam int         c_PW     = $clog2(NREQ);
  localparam logic [3:0] c_HOLD   = 4'(HOLD);
  localparam logic [c_PW-1:0] c_PTR_RST = c_PW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAKE = 2'd1,
    S_RUN  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_idle_cnt;
  logic [3:0]        w_idle_nxt;
  logic [c_PW-1:0]   r_rr_ptr;
  logic [c_PW-1:0]   w_gidx;
  logic              w_found;
  logic [NREQ-1:0]   w_gnt;
  logic              w_blocked;
  logic              w_go;
  logic              w_grant_ok;
  logic              r_tc;

  assign w_blocked  = (limit != '0) && (count_in == limit);
  assign w_go       = (|req) && !w_blocked;
  assign w_grant_ok = (r_state == S_RUN) && w_go;

  assign gnt      = w_gnt;
  assign increase = |w_gnt;
  assign busy     = (r_state != S_IDLE);
  assign cg_en    = (r_state != S_IDLE);
  assign tc       = r_tc;

  // Round-robin pick: first requesting index strictly after the last winner.
  always_comb begin
    int k;
    k       = 0;
    w_gnt   = '0;
    w_gidx  = r_rr_ptr;
    w_found = 1'b0;
    if (w_grant_ok) begin
      for (int i = 1; i <= NREQ; i++) begin
        k = (int'(r_rr_ptr) + i) % NREQ;
        if (!w_found && req[k]) begin
          w_found = 1'b1;
          w_gidx  = k[c_PW-1:0];
        end
      end
    end
    if (w_found) begin
      w_gnt[w_gidx] = 1'b1;
    end
  end

  // Next-state logic; the HOLD state lasts exactly HOLD cycles when idle.
  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = r_idle_cnt;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_nxt = S_WAKE;
        end
      end
      S_WAKE: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!w_grant_ok) begin
          if (c_HOLD == 4'd0) begin
            w_state_nxt = S_IDLE;
            w_idle_nxt  = 4'd0;
          end else begin
            w_state_nxt = S_HOLD;
            w_idle_nxt  = c_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (w_go) begin
          w_state_nxt = S_RUN;
        end else if (r_idle_cnt <= 4'd1) begin
          w_state_nxt = S_IDLE;
          w_idle_nxt  = 4'd0;
        end else begin
          w_idle_nxt = r_idle_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idle_nxt  = 4'd0;
      end
    endcase
  end

  // State, hold counter and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_idle_cnt <= 4'd0;
      r_rr_ptr   <= c_PTR_RST;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_nxt;
      if (w_found) begin
        r_rr_ptr <= w_gidx;
      end
    end
  end

  // Sticky terminal-count flag; a blocked cycle takes priority over clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tc <= 1'b0;
    end else if (w_blocked) begin
      r_tc <= 1'b1;
    end else if (clr) begin
      r_tc <= 1'b0;
    end
  end

`ifdef CNT_SCHED_STATS_EN
  logic [15:0] r_grant_total;
  assign grant_total = r_grant_total;

  // Saturating count of grant cycles; clr wins over a same-cycle grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant_total <= 16'd0;
    end else if (clr) begin
      r_grant_total <= 16'd0;
    end else if (increase && (r_grant_total != 16'hFFFF)) begin
      r_grant_total <= r_grant_total + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire
